// File: rtl/puf_pkg.sv
// Shared constants and state encoding for the arbiter-PUF challenge sequencer.
package puf_pkg;

    // x^128 + x^126 + x^101 + x^99 + 1 (maximal length), taps at bits 127,125,100,98
    localparam logic [127:0] LFSR_TAPS_128    = 128'hA000_0014_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] DEFAULT_SEED_128 = '1;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        LAUNCH,
        SETTLE_HI,
        SAMPLE,
        SETTLE_LO,
        DONE
    } puf_state_e;

endpackage

// File: rtl/puf_lfsr.sv
// Fibonacci LFSR supplying PUF challenges; a zero seed is replaced by all-ones.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int                CHAL_W = 128,
    parameter logic [CHAL_W-1:0] TAPS   = LFSR_TAPS_128[CHAL_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CHAL_W-1:0] seed,
    input  logic              step,
    output logic [CHAL_W-1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '1;
        end else if (load) begin
            state <= (seed == '0) ? '1 : seed;
        end else if (step) begin
            state <= {state[CHAL_W-2:0], ^(state & TAPS)};
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives challenges and the race edge into the arbiter PUF, samples the settled
// arbiter output and packs RESP_W response bits into a handshaked word.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int                CHAL_W     = 128,
    parameter int                RESP_W     = 32,
    parameter int                SETTLE_CYC = 8,
    parameter logic [CHAL_W-1:0] LFSR_TAPS  = LFSR_TAPS_128[CHAL_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] chal,
    output logic              launch,
    input  logic              puf_q,
    output logic [RESP_W-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int BCW = $clog2(RESP_W + 1);
    localparam int SCW = $clog2(SETTLE_CYC + 1);

    puf_state_e     state;
    logic [BCW-1:0] bit_cnt;
    logic [SCW-1:0] set_cnt;
    logic           q_meta, q_sync;
    logic           start_pend;
    logic           lfsr_load, lfsr_step;

    assign lfsr_load = (state == IDLE) && seed_load;
    assign lfsr_step = (state == SAMPLE);

    puf_lfsr #(
        .CHAL_W (CHAL_W),
        .TAPS   (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (chal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            launch     <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            set_cnt    <= '0;
            q_meta     <= 1'b0;
            q_sync     <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            q_meta <= puf_q;
            q_sync <= q_meta;
            case (state)
                IDLE: begin
                    // a start coinciding with a seed load waits one cycle for the new challenge
                    if (seed_load) begin
                        start_pend <= start;
                    end else if (start || start_pend) begin
                        start_pend <= 1'b0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    launch <= 1'b0;
                    state  <= LAUNCH;
                end
                LAUNCH: begin
                    launch  <= 1'b1;
                    set_cnt <= '0;
                    state   <= SETTLE_HI;
                end
                SETTLE_HI: begin
                    if (set_cnt == SCW'(SETTLE_CYC - 1)) begin
                        set_cnt <= '0;
                        state   <= SAMPLE;
                    end else begin
                        set_cnt <= set_cnt + SCW'(1);
                    end
                end
                SAMPLE: begin
                    for (int i = 0; i < RESP_W; i++) begin
                        if (bit_cnt == BCW'(i)) resp[i] <= q_sync;
                    end
                    bit_cnt <= bit_cnt + BCW'(1);
                    launch  <= 1'b0;
                    set_cnt <= '0;
                    state   <= SETTLE_LO;
                end
                SETTLE_LO: begin
                    if (set_cnt == SCW'(SETTLE_CYC - 1)) begin
                        set_cnt <= '0;
                        if (bit_cnt == BCW'(RESP_W)) begin
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= APPLY;
                        end
                    end else begin
                        set_cnt <= set_cnt + SCW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        bit_cnt    <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: vector table of seeds and PUF behaviours
// plus hand sequences for backpressure, deferred start, zero seed and async reset.
module tb_puf_challenge_sequencer;

    logic         clk = 1'b0;
    logic         rst, start, seed_load, puf_q, resp_ready;
    logic [127:0] seed, chal;
    logic         launch, resp_valid, busy;
    logic [31:0]  resp;

    int total = 0;
    int bad   = 0;
    int mode  = 1;  // 0: puf_q=0, 1: puf_q=1, 2: puf_q=chal[0]

    localparam logic [127:0] ONES = '1;

    always #5 clk = ~clk;

    assign puf_q = (mode == 2) ? chal[0] : (mode == 1);

    puf_challenge_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .chal       (chal),
        .launch     (launch),
        .puf_q      (puf_q),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    // independent reference: x^128 + x^126 + x^101 + x^99 + 1
    function automatic logic [127:0] ref_step(input logic [127:0] v);
        return {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // challenge-sequence and launch-width monitor
    logic         mon_en = 1'b0;
    logic [127:0] mdl = '1;
    int           mon_steps = 0;
    int           lw = 0;

    always @(negedge clk) begin
        if (mon_en && chal !== mdl) begin
            mdl = ref_step(mdl);
            mon_steps++;
            chk("chal_seq", chal, mdl);
            chk("chal_change_launch_low", {127'd0, launch}, 128'd0);
        end
        if (launch) lw++;
        else if (lw != 0) begin
            if (mon_en) chk("launch_width", lw, 9);
            lw = 0;
        end
    end

    task automatic load_seed(input logic [127:0] s);
        @(posedge clk); #1;
        seed = s; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    // returns number of edges from the start-sampling edge until resp_valid is seen
    task automatic start_and_wait(output int n);
        start = 1'b1;
        @(posedge clk); n = 1; #1;
        start = 1'b0;
        while (!resp_valid && n < 2000) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!resp_valid && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("valid_timeout", {127'd0, resp_valid}, 128'd1);
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("accept_valid_low", {127'd0, resp_valid}, 128'd0);
        chk("accept_idle", {127'd0, busy}, 128'd0);
    endtask

    typedef struct {
        logic [127:0] seed;
        int           mode;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        logic stable;
        vecs[0] = '{128'd1,               1, 32'hFFFF_FFFF};
        vecs[1] = '{128'd1,               2, 32'h0000_0001};
        vecs[2] = '{128'd1 << 127,        2, 32'h0000_0002};
        vecs[3] = '{128'd1 << 125,        2, 32'h0000_000A};
        vecs[4] = '{128'd0,               0, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; resp_ready = 1'b0;
        #12;
        chk("rst_chal", chal, ONES);
        chk("rst_launch", {127'd0, launch}, 128'd0);
        chk("rst_resp", {96'd0, resp}, 128'd0);
        chk("rst_valid", {127'd0, resp_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        @(negedge clk); rst = 1'b0;

        // table-driven words
        for (int k = 0; k < 5; k++) begin
            mon_en = 1'b0;
            mode = vecs[k].mode;
            load_seed(vecs[k].seed);
            mdl = (vecs[k].seed == '0) ? ONES : vecs[k].seed;
            chk("seed_loaded", chal, mdl);
            mon_en = 1'b1;
            start_and_wait(n);
            chk("latency", n, 609);
            chk("resp", {96'd0, resp}, {96'd0, vecs[k].exp});
            chk("busy_in_done", {127'd0, busy}, 128'd1);
            accept();
        end

        // start alongside seed_load is deferred by one cycle
        mon_en = 1'b0;
        mode = 2;
        @(posedge clk); #1;
        seed = 128'd1 << 125; seed_load = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0; start = 1'b0;
        chk("defer_chal", chal, 128'd1 << 125);
        chk("defer_still_idle", {127'd0, busy}, 128'd0);
        mdl = 128'd1 << 125;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("defer_busy", {127'd0, busy}, 128'd1);
        wait_valid();
        chk("defer_resp", {96'd0, resp}, 128'h0A);

        // backpressure: hold 50 cycles with a stray start, then one transfer
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            start = (c == 10);
            @(posedge clk); #1;
            if (resp !== 32'h0000_000A || resp_valid !== 1'b1) stable = 1'b0;
        end
        start = 1'b0;
        chk("bp_stable", {127'd0, stable}, 128'd1);
        accept();
        repeat (5) @(posedge clk);
        #1 chk("bp_start_not_queued", {127'd0, busy}, 128'd0);

        // zero seed: all-ones, no lockup across 224 steps
        mon_en = 1'b0;
        mode = 1;
        load_seed(128'd0);
        chk("zero_seed_ones", chal, ONES);
        mdl = ONES; mon_steps = 0;
        mon_en = 1'b1;
        for (int w = 0; w < 7; w++) begin
            start_and_wait(n);
            chk("zero_seed_word", {96'd0, resp}, 128'hFFFF_FFFF);
            chk("nonzero_chal", {127'd0, chal == '0}, 128'd0);
            accept();
        end
        chk("zero_seed_steps", mon_steps, 224);

        // asynchronous reset in the middle of SETTLE_HI
        mon_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!launch && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("launch_seen", {127'd0, launch}, 128'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_launch", {127'd0, launch}, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_valid", {127'd0, resp_valid}, 128'd0);
        chk("arst_chal", chal, ONES);
        chk("arst_resp", {96'd0, resp}, 128'd0);
        @(negedge clk); rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Control stage directly upstream and downstream of the 128-stage arbiter PUF.
- Generates successive challenges from an internal LFSR and drives the shared race edge onto the PUF's two path inputs.
- Waits for the race to settle, then samples the arbiter output through a 2-flop synchronizer and packs RESP_W single-bit responses into one response word.
- Hands the word to the consumer with a valid/ready handshake.

Parameters:
- CHAL_W, 128: challenge width; equals the PUF stage count.
- RESP_W, 32: response bits collected per word; legal range 1..64.
- SETTLE_CYC, 8: clock cycles to wait after the launch edge and after the launch fall before acting; must be ≥2.
- LFSR_TAPS, 128'h…(maximal-length polynomial from the shared package): feedback taps of the Fibonacci LFSR.

Ports:
- clk, input, 1: single clock for all state.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle request to begin a new response word; ignored unless in IDLE.
- seed_load, input, 1: loads seed into the LFSR; honoured only in IDLE.
- seed, input, CHAL_W: LFSR seed value.
- chal, output, CHAL_W: challenge driven to the PUF Chal bus.
- launch, output, 1: race edge driven to both PUF path inputs (in_X and in_Y).
- puf_q, input, 1: arbiter output from the PUF.
- resp, output, RESP_W: packed response word; bit i is the response to the i-th challenge of the word.
- resp_valid, output, 1: resp holds a complete word.
- resp_ready, input, 1: consumer accepts resp.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous on rst=1): state=IDLE; LFSR=all-ones default seed (never zero); chal=LFSR value; launch=0; resp=0; resp_valid=0; busy=0; bit counter=0; settle counter=0; synchronizer flops=0.

States and transitions:
- IDLE
  - seed_load=1: LFSR←seed. A seed of 0 is replaced by all-ones.
  - start=1 (same cycle as seed_load): seed_load is applied first; start is honoured on the next cycle.
  - start=1 (otherwise): → APPLY.
- APPLY: chal is already stable from the previous LFSR step; launch=0. One cycle for challenge setup, then → LAUNCH.
- LAUNCH: launch←1; clear settle counter; → SETTLE_HI.
- SETTLE_HI: count SETTLE_CYC cycles, then → SAMPLE.
- SAMPLE
  - Shift the synchronized puf_q into resp at position bit_cnt: resp[bit_cnt]←q_sync.
  - bit_cnt++.
  - Advance the LFSR one step; chal updates.
  - launch←0; → SETTLE_LO.
- SETTLE_LO: count SETTLE_CYC cycles with launch=0 so both paths return low.
  - bit_cnt==RESP_W: → DONE.
  - Otherwise: → APPLY.
- DONE
  - resp_valid=1; resp held stable.
  - resp_ready=1: transfer occurs; resp_valid←0; bit_cnt←0; → IDLE.
  - resp and resp_valid must not change while resp_valid=1 and resp_ready=0.

Other rules:
- Latency per bit: 1 (APPLY) + 1 (LAUNCH) + SETTLE_CYC + 1 (SAMPLE) + SETTLE_CYC = 2·SETTLE_CYC+3 cycles. With defaults this is 19 cycles/bit, i.e. 608 cycles from start to resp_valid, plus 1 IDLE→APPLY cycle.
- The synchronizer samples puf_q every cycle. With SETTLE_CYC ≥2, q_sync is valid by the time SAMPLE is reached.
- chal changes only in SAMPLE and on seed_load, never while launch=1.
- start during busy: ignored, not queued.
- resp bits not yet written within a word read as their value from the previous word. resp is cleared to 0 only on reset.
- rst mid-operation: all state returns to reset values immediately; launch drops asynchronously.

Decomposition:
- Shared package puf_pkg holds:
  - LFSR_TAPS_128 constant;
  - default seed constant;
  - the state enum (IDLE, APPLY, LAUNCH, SETTLE_HI, SAMPLE, SETTLE_LO, DONE).
- One sub-module, puf_lfsr: CHAL_W-wide Fibonacci LFSR with load, step and zero-seed guard.
- The synchronizer is inline: two flops.

Test Plan:
- Reset/idle:
  - Assert rst mid-SETTLE_HI → launch=0, busy=0, resp_valid=0 in the same cycle.
  - chal returns to all-ones.
- Seeded sequence:
  - seed_load with seed=1, then start.
  - chal sequence matches the package reference LFSR model for 32 steps.
  - chal is never changed while launch=1.
- Constant PUF:
  - Tie puf_q=1, RESP_W=32, SETTLE_CYC=8.
  - resp_valid rises exactly 609 cycles after start; resp=32'hFFFF_FFFF.
- Pattern capture:
  - A bench model returns chal[0] as puf_q.
  - resp bit i equals bit 0 of the i-th challenge.
  - Launch pulse width equals SETTLE_CYC+1 cycles.
- Backpressure:
  - Hold resp_ready=0 for 50 cycles in DONE → resp stable; resp_valid stays 1; start is ignored.
  - Release → one transfer, then IDLE.
- Zero seed:
  - seed_load with seed=0 → LFSR loads all-ones; no lockup over 200 steps.
